// File: rtl/shiftadd_pkg.sv
// Shared definitions for the shift-add multiplier: controller states, default width,
// and the datapath product width.
package shiftadd_pkg;

  localparam int N_DEFAULT = 4;

  // The product register carries one extra bit for the carry out of the add.
  function automatic int prod_width(input int n);
    return 2 * n + 1;
  endfunction

  localparam int PROD_W_DEFAULT = prod_width(N_DEFAULT);

  // Encodings 6 and 7 are unused; the controller sends them back to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Counter width that stays legal when N is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrl_shiftadd_multiplier.sv
// Moore controller sequencing the shift-add datapath: load, then N rounds of
// (optional add on product LSB, shift), then a one-cycle done pulse.
module ctrl_shiftadd_multiplier
  import shiftadd_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lsb,
  output logic load,
  output logic add,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // start and lsb only matter in the one state that samples them.
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  state_d = start ? LOAD : IDLE;
      LOAD: begin
        cnt_d   = '0;
        state_d = CHECK;
      end
      CHECK: state_d = lsb ? ADD : SHIFT;
      ADD:   state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = CHECK;
        end
      end
      DONE:  state_d = IDLE;
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs depend on the state register alone, so strobes are one-hot by construction.
  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    done  = 1'b0;
    busy  = 1'b0;
    unique case (state_q)
      LOAD:  begin load  = 1'b1; busy = 1'b1; end
      CHECK: busy = 1'b1;
      ADD:   begin add   = 1'b1; busy = 1'b1; end
      SHIFT: begin shift = 1'b1; busy = 1'b1; end
      DONE:  begin done  = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_shiftadd_multiplier.sv
// Controller plus a behavioural datapath, checked against plain arithmetic:
// product = mult*mcand, done in cycle 2+2N+popcount(mult), strobe order from multiplier bits.
module tb_ctrl_shiftadd_multiplier;

  localparam int N = 4;
  localparam int PW = 2 * N + 1;

  logic clk = 1'b0;
  logic rst, start, lsb;
  logic load, add, shift, busy, done;
  logic [PW-1:0] product;
  logic [N-1:0]  mult_r, mcand_r;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_shiftadd_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .lsb   (lsb),
    .load  (load),
    .add   (add),
    .shift (shift),
    .busy  (busy),
    .done  (done)
  );

  // Datapath as the controller expects it: load clears the upper half.
  always_ff @(posedge clk) begin
    if (load)
      product <= {{(N+1){1'b0}}, mult_r};
    else if (add)
      product[2*N:N] <= {1'b0, product[2*N-1:N]} + {1'b0, mcand_r};
    else if (shift)
      product <= product >> 1;
  end

  assign lsb = product[0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_strobes"}, 64'({load, add, shift, done}), 64'd0);
  endtask

  // Caller is at a negedge with the controller in IDLE; returns at the negedge of the done cycle.
  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] c,
                        input bit hold, input bit poke);
    int cyc, adds, multi;
    logic [63:0] trace, exp_trace;
    int exp_lat;
    mult_r  = m;
    mcand_r = c;
    start   = 1'b1;
    @(negedge clk);
    start = hold;
    cyc   = 1;
    trace = '0;
    adds  = 0;
    multi = 0;
    // Codes: 1=load, 2=add, 3=shift.
    exp_trace = 64'd1;
    for (int i = 0; i < N; i++) begin
      if (m[i]) exp_trace = (exp_trace << 2) | 64'd2;
      exp_trace = (exp_trace << 2) | 64'd3;
    end
    exp_lat = 2 + 2 * N + $countones(m);
    check("load_in_cycle1", 64'(load), 64'd1);
    for (int guard = 0; guard < 40; guard++) begin
      if (int'(load) + int'(add) + int'(shift) > 1) multi++;
      if (load)  trace = (trace << 2) | 64'd1;
      if (add)   begin trace = (trace << 2) | 64'd2; adds++; end
      if (shift) trace = (trace << 2) | 64'd3;
      if (done) break;
      start = (poke && cyc == 2) ? 1'b1 : hold;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("done_cycle", 64'(cyc), 64'(exp_lat));
    check("product", 64'(product[2*N-1:0]), 64'(int'(m) * int'(c)));
    check("product_msb", 64'(product[2*N]), 64'd0);
    check("strobe_trace", trace, exp_trace);
    check("add_count", 64'(adds), 64'($countones(m)));
    check("strobe_overlap", 64'(multi), 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    mult_r  = '0;
    mcand_r = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    run_op(4'd3, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("after_3x5");

    run_op(4'd0, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("after_0x9");

    run_op(4'd15, 4'd15, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("after_15x15");

    // start pulsed in CHECK inside the task, then again in DONE here.
    run_op(4'd5, 4'd3, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_idle("poke_done_idle");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_idle("poke_quiet");
    end

    // Reset during ADD aborts at once.
    mult_r  = 4'd1;
    mcand_r = 4'd5;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 10 && !add; g++) @(negedge clk);
    check("reached_add", 64'(add), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_in_add");
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_released");
    run_op(4'd6, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("after_6x7");

    // start held high: one IDLE cycle between back-to-back runs.
    run_op(4'd2, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    check("held_idle_busy", 64'(busy), 64'd0);
    run_op(4'd4, 4'd4, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check_idle("held_end");
    @(negedge clk);
    check_idle("held_stays_idle");

    for (int r = 0; r < 8; r++) begin
      run_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 1'b0, 1'b0);
      @(negedge clk);
      check_idle("rand_after");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
